// File: rtl/mips_trace_buffer_if.sv
// mips_trace_buffer_if
//   Bundles the two data paths of the trace buffer into one interface.
//   Capture side:  cap_valid strobe plus the sample fields
//                  (inst_num, result, overflow, equal, carry).
//   Readout side:  rd_valid/rd_ready handshake and rd_data, the oldest unread entry.
//   Modports:
//     master - the sample producer and trace reader (the Mips side, a bench or a debug port)
//     slave  - the trace buffer itself
//   Entry layout on rd_data: {inst_num, overflow, equal, carry, result}.
interface mips_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int INUM_W = 6
) ();
  localparam int ENTRY_W = INUM_W + 3 + DATA_W;

  logic               cap_valid;
  logic [INUM_W-1:0]  inst_num;
  logic [DATA_W-1:0]  result;
  logic               overflow;
  logic               equal;
  logic               carry;
  logic               rd_ready;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output cap_valid, inst_num, result, overflow, equal, carry, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  cap_valid, inst_num, result, overflow, equal, carry, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer
//   Armable circular trace buffer for the Mips ALU outputs.
//   After arm it records every strobed sample, keeping the newest DEPTH of them.
//   A flag-match trigger then opens a post-trigger window of POST_TRIG further samples.
//   When the window closes, the entries are read out oldest first.
//   Ports:
//     clk, rst_n             clock; synchronous active-low reset
//     arm, clear             control pulses (clear wins over arm)
//     trig_mask, trig_value  trigger: {ovf,eq,cy} masked compare
//     bus                    capture strobe/fields and readout handshake (slave modport)
//     state                  0 IDLE, 1 ARMED, 2 POST, 3 DONE
//     count                  entries held / remaining to read
//     lost                   pre-trigger entries overwritten (saturating)
module mips_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int INUM_W    = 6,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     clear,
  input  logic [2:0]               trig_mask,
  input  logic [2:0]               trig_value,
  mips_trace_buffer_if.slave       bus,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              lost
);
  localparam int ENTRY_W = INUM_W + 3 + DATA_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
  logic [15:0]        lost_q, lost_d;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [2:0]         flags;
  logic               trig_hit;
  logic               start;
  logic               wr_en;
  logic               full;
  logic               rd_fire;
  logic               rd_valid_int;
  logic [CNT_W-1:0]   post_cnt_inc;
  logic [ENTRY_W-1:0] wr_entry;

  assign flags        = {bus.overflow, bus.equal, bus.carry};
  assign trig_hit     = bus.cap_valid && (((flags ^ trig_value) & trig_mask) == 3'b000);
  // Restart is allowed only from a quiescent state; a simultaneous clear overrides it.
  assign start        = arm && !clear && (state_q == S_IDLE || state_q == S_DONE);
  // Samples go straight into memory on the edge they are strobed (no input staging).
  assign wr_en        = bus.cap_valid && !clear && (state_q == S_ARMED || state_q == S_POST);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign rd_valid_int = (state_q == S_DONE) && (count_q != '0);
  assign rd_fire      = rd_valid_int && bus.rd_ready && !clear && !start;
  assign post_cnt_inc = post_cnt_q + CNT_W'(1);
  assign wr_entry     = {bus.inst_num, bus.overflow, bus.equal, bus.carry, bus.result};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm) state_d = S_ARMED;
        S_ARMED: if (trig_hit) state_d = (POST_TRIG == 0) ? S_DONE : S_POST;
        // The write that brings the window count up to POST_TRIG closes the window.
        S_POST:  if (bus.cap_valid && post_cnt_inc == CNT_W'(POST_TRIG)) state_d = S_DONE;
        S_DONE:  if (arm) state_d = S_ARMED;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    state        = state_q;
    count        = count_q;
    lost         = lost_q;
    bus.rd_valid = rd_valid_int;
    // Zero-latency read from the registered pointer; held at zero when nothing is readable.
    bus.rd_data  = rd_valid_int ? mem[rd_ptr_q] : '0;
  end

  // Pointer / counter next values
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    lost_d     = lost_q;
    if (clear) begin
      // lost is deliberately kept so it can be inspected after an abort.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
    end else if (start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      lost_d     = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (full) begin
        // Ring full: the oldest entry is overwritten, so the read side moves past it.
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (state_q == S_ARMED && lost_q != 16'hFFFF) begin
          lost_d = lost_q + 16'd1;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      post_cnt_d = (state_q == S_ARMED) ? '0 : post_cnt_inc;
    end else if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      lost_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      lost_q     <= lost_d;
    end
  end

  // Storage array; contents need no reset because count/rd_valid gate visibility.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr_q] <= wr_entry;
    end
  end
endmodule
